// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the
// processor load/store path (port 0) and a DMA/debug loader (port 1).
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              gnt_id,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   we_q;
  logic   pick1;

  // Port 1 wins if it is the only requester, or on a tie when port 0 went last.
  assign pick1 = req1 & (~req0 | ~last);

  // Strobes are gated with rst so a reset edge landing on ACCESS never commits a write.
  assign mem_read  = (state == ACCESS) & ~we_q & ~rst;
  assign mem_write = (state == ACCESS) &  we_q & ~rst;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of state, gnt_id and we_q regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      we_q      <= 1'b0;
      gnt_id    <= 1'b0;
      busy      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_adr   <= '0;
      mem_wdata <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt_id    <= pick1;
            last      <= pick1;
            we_q      <= pick1 ? we1    : we0;
            mem_adr   <= pick1 ? adr1   : adr0;
            mem_wdata <= pick1 ? wdata1 : wdata0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (gnt_id) rdata1 <= mem_data;
            else        rdata0 <= mem_data;
          end
          ack0  <= ~gnt_id;
          ack1  <=  gnt_id;
          state <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural 1024x16 memory preloaded with
// 0xC000|address, one task per scenario with hand-computed expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [9:0]  adr0 = '0, adr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, gnt_id, busy, mem_read, mem_write;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_data;
  logic [9:0]  mem_adr;

  logic [15:0] mem [1024];
  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt_id(gnt_id), .busy(busy),
    .mem_adr(mem_adr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_adr] <= mem_wdata;
  assign mem_data = mem_read ? mem[mem_adr] : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req0 = 1'b0; req1 = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b1; we0 = 1'b1; adr0 = 10'h003; wdata0 = 16'hBEEF; rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write cyc%0d: got %b want 0", c, mem_write); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy cyc%0d: got %b want 0", c, busy); end
    end
    vectors++; if ({ack0, ack1} !== 2'b00) begin miscompares++; $display("FAIL reset_acks: got %b want 00", {ack0, ack1}); end
    vectors++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin miscompares++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", rdata0, rdata1); end
    vectors++; if (mem_adr !== 10'h0 || mem_wdata !== 16'h0) begin miscompares++; $display("FAIL reset_mem_bus: got %h/%h want 000/0000", mem_adr, mem_wdata); end
    vectors++; if (gnt_id !== 1'b0 || mem_read !== 1'b0) begin miscompares++; $display("FAIL reset_gnt_read: got %b/%b want 0/0", gnt_id, mem_read); end
    req0 = 1'b0; rst = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_write_read();
    apply_reset();
    req0 = 1'b1; we0 = 1'b1; adr0 = 10'h005; wdata0 = 16'h1234;
    tick();
    vectors++; if ({busy, gnt_id, mem_write, mem_read} !== 4'b1010) begin miscompares++; $display("FAIL wr_access_ctl: got %b want 1010", {busy, gnt_id, mem_write, mem_read}); end
    vectors++; if (mem_adr !== 10'h005 || mem_wdata !== 16'h1234) begin miscompares++; $display("FAIL wr_access_bus: got %h/%h want 005/1234", mem_adr, mem_wdata); end
    tick();
    vectors++; if ({ack0, ack1, mem_write} !== 3'b100) begin miscompares++; $display("FAIL wr_ack: ack0/ack1/mem_write got %b want 100", {ack0, ack1, mem_write}); end
    vectors++; if (mem[5] !== 16'h1234) begin miscompares++; $display("FAIL wr_mem: got %h want 1234", mem[5]); end
    req0 = 1'b0;
    tick();
    vectors++; if ({ack0, ack1, busy} !== 3'b000) begin miscompares++; $display("FAIL wr_idle: got %b want 000", {ack0, ack1, busy}); end
    req0 = 1'b1; we0 = 1'b0; adr0 = 10'h005; wdata0 = 16'h0000;
    tick();
    vectors++; if ({mem_read, mem_write, ack0, ack1} !== 4'b1000) begin miscompares++; $display("FAIL rd_access: got %b want 1000", {mem_read, mem_write, ack0, ack1}); end
    tick();
    vectors++; if ({ack0, ack1} !== 2'b10) begin miscompares++; $display("FAIL rd_ack: got %b want 10", {ack0, ack1}); end
    vectors++; if (rdata0 !== 16'h1234) begin miscompares++; $display("FAIL rd_data: got %h want 1234", rdata0); end
    req0 = 1'b0;
    tick();
    vectors++; if (ack0 !== 1'b0 || rdata0 !== 16'h1234 || rdata1 !== 16'h0) begin miscompares++; $display("FAIL rd_hold: ack0=%b rdata0=%h rdata1=%h want 0/1234/0000", ack0, rdata0, rdata1); end
    apply_reset();
    vectors++; if (rdata0 !== 16'h0) begin miscompares++; $display("FAIL rd_clear: got %h want 0000", rdata0); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req0 = 1'b1; we0 = 1'b0; adr0 = 10'h010;
    req1 = 1'b1; we1 = 1'b0; adr1 = 10'h020;
    tick();
    vectors++; if (gnt_id !== 1'b0 || mem_adr !== 10'h010) begin miscompares++; $display("FAIL sim_gnt0: gnt=%b adr=%h want 0/010", gnt_id, mem_adr); end
    tick();
    vectors++; if ({ack0, ack1} !== 2'b10 || rdata0 !== 16'hC010) begin miscompares++; $display("FAIL sim_ack0: acks=%b rdata0=%h want 10/C010", {ack0, ack1}, rdata0); end
    req0 = 1'b0;
    tick();
    vectors++; if ({busy, ack0, ack1} !== 3'b000) begin miscompares++; $display("FAIL sim_idle: got %b want 000", {busy, ack0, ack1}); end
    tick();
    vectors++; if (gnt_id !== 1'b1 || mem_adr !== 10'h020 || mem_read !== 1'b1) begin miscompares++; $display("FAIL sim_gnt1: gnt=%b adr=%h rd=%b want 1/020/1", gnt_id, mem_adr, mem_read); end
    tick();
    vectors++; if ({ack0, ack1} !== 2'b01) begin miscompares++; $display("FAIL sim_ack1: got %b want 01", {ack0, ack1}); end
    vectors++; if (rdata1 !== 16'hC020 || rdata0 !== 16'hC010) begin miscompares++; $display("FAIL sim_rdata: got %h/%h want C010/C020", rdata0, rdata1); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int k = 0;
    apply_reset();
    req0 = 1'b1; we0 = 1'b0; adr0 = 10'h100;
    req1 = 1'b1; we1 = 1'b0; adr1 = 10'h200;
    for (int c = 0; c < 40 && k < 8; c++) begin
      tick();
      if (ack0 && ack1) begin vectors++; miscompares++; $display("FAIL cont_both_ack: cycle %0d got 11 want one-hot", c); end
      if (ack0 || ack1) begin
        vectors++;
        if (gnt_id !== k[0] || ack1 !== k[0]) begin miscompares++; $display("FAIL cont_order #%0d: gnt=%b ack1=%b want %b", k, gnt_id, ack1, k[0]); end
        vectors++;
        if ((k[0] ? rdata1 : rdata0) !== (k[0] ? 16'hC200 : 16'hC100)) begin miscompares++; $display("FAIL cont_rdata #%0d: got %h/%h", k, rdata0, rdata1); end
        k++;
      end
    end
    vectors++; if (k != 8) begin miscompares++; $display("FAIL cont_timeout: acks got %0d want 8", k); end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_during_write();
    apply_reset();
    req1 = 1'b1; we1 = 1'b1; adr1 = 10'h3FF; wdata1 = 16'h00FF;
    tick();
    vectors++; if (mem_write !== 1'b1 || gnt_id !== 1'b1) begin miscompares++; $display("FAIL rstw_access: wr=%b gnt=%b want 1/1", mem_write, gnt_id); end
    rst = 1'b1; req1 = 1'b0;
    #1;
    vectors++; if ({mem_write, mem_read} !== 2'b00) begin miscompares++; $display("FAIL rstw_gate: got %b want 00", {mem_write, mem_read}); end
    tick();
    rst = 1'b0;
    vectors++; if (mem[10'h3FF] !== 16'hC3FF) begin miscompares++; $display("FAIL rstw_mem: got %h want C3FF", mem[10'h3FF]); end
    vectors++; if ({busy, ack1} !== 2'b00) begin miscompares++; $display("FAIL rstw_state: busy/ack1 got %b want 00", {busy, ack1}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if ({ack0, ack1, busy} !== 3'b000) begin miscompares++; $display("FAIL rstw_no_ack cyc%0d: got %b want 000", c, {ack0, ack1, busy}); end
    end
  endtask

  task automatic test_req_change();
    apply_reset();
    req0 = 1'b1; we0 = 1'b0; adr0 = 10'h001; wdata0 = 16'h0000;
    tick();
    adr0 = 10'h002; we0 = 1'b1; wdata0 = 16'hFFFF;
    #1;
    vectors++; if (mem_adr !== 10'h001 || {mem_read, mem_write} !== 2'b10) begin miscompares++; $display("FAIL chg_access: adr=%h rd/wr=%b want 001/10", mem_adr, {mem_read, mem_write}); end
    tick();
    vectors++; if (ack0 !== 1'b1 || rdata0 !== 16'hC001) begin miscompares++; $display("FAIL chg_result: ack0=%b rdata0=%h want 1/C001", ack0, rdata0); end
    vectors++; if (mem[2] !== 16'hC002) begin miscompares++; $display("FAIL chg_mem2: got %h want C002", mem[2]); end
    req0 = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hC000 | 16'(i);
    test_reset();
    test_write_read();
    test_simultaneous();
    test_contention();
    test_reset_during_write();
    test_req_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
